// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 instruction fetch unit.
//   XLEN             : PC / fetch address width
//   INST_W           : instruction word width
//   RESET_PC_DEFAULT : PC loaded on reset
//   NOP              : addi x0, x0, 0, issued in place of a misaligned fetch
//   ifu_state_e      : fetch FSM states
//   pc_sel_e         : next-PC mux select (hold / pc+4 / redirect)
package ysyx_220053_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] NOP              = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrain
    } ifu_state_e;

    typedef enum logic [1:0] {
        PcHold,
        PcInc,
        PcRedirect
    } pc_sel_e;

endpackage

// File: rtl/ysyx_220053_pc_reg.sv
// Program counter register with its next-PC mux.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (PC -> RESET_PC)
//   i_sel          : PcHold keeps the PC, PcInc adds 4 (wraps), PcRedirect loads i_redirect_pc
//   i_redirect_pc  : redirect target
//   o_pc           : current PC (registered)
module ysyx_220053_pc_reg
    import ysyx_220053_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  pc_sel_e         i_sel,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        unique case (i_sel)
            PcInc:      w_pc_next = r_pc + 64'd4;
            PcRedirect: w_pc_next = i_redirect_pc;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: holds the PC, issues one word fetch at a time to instruction memory
// and hands the fetched word plus its PC to decode. Execute may redirect the PC at any time;
// a request abandoned by a redirect has its response drained and dropped.
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   o_imem_req_valid/i_imem_req_ready/o_imem_req_addr : fetch request (addr = pc)
//   i_imem_rsp_valid/i_imem_rsp_data : fetch response, one-cycle pulse
//   o_inst_valid/i_inst_ready/o_inst/o_inst_pc        : instruction to decode
//   i_redirect_valid/i_redirect_pc   : PC change from execute (highest priority)
//   o_fetch_fault                    : misaligned-PC fault, qualified by o_inst_valid
// Build option: YSYX_220053_IFU_ALIGN_CHECK_EN enables the misaligned-PC check; without it
// the PC is fetched as-is and o_fetch_fault stays 0.
module ysyx_220053_ifu
    import ysyx_220053_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [XLEN-1:0]   o_imem_req_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [XLEN-1:0]   o_inst_pc,
    input  logic              i_redirect_valid,
    input  logic [XLEN-1:0]   i_redirect_pc,
    output logic              o_fetch_fault
);

    ifu_state_e        r_state, w_state_d;
    logic [INST_W-1:0] r_inst, w_inst_d;
    logic [XLEN-1:0]   r_inst_pc, w_inst_pc_d;
    logic              r_fault, w_fault_d;
    pc_sel_e           w_pc_sel;
    logic [XLEN-1:0]   w_pc;
    logic              w_misaligned;
    logic              w_req_fire;

    ysyx_220053_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sel        (w_pc_sel),
        .i_redirect_pc(i_redirect_pc),
        .o_pc         (w_pc)
    );

`ifdef YSYX_220053_IFU_ALIGN_CHECK_EN
    assign w_misaligned = (w_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Outputs decode only state and registers; no input reaches an output combinationally.
    assign o_imem_req_valid = (r_state == StReq) && !w_misaligned;
    assign o_imem_req_addr  = w_pc;
    assign o_inst_valid     = (r_state == StHold);
    assign o_inst           = r_inst;
    assign o_inst_pc        = r_inst_pc;
    assign o_fetch_fault    = r_fault;

    assign w_req_fire = o_imem_req_valid && i_imem_req_ready;

    always_comb begin
        w_state_d   = r_state;
        w_pc_sel    = PcHold;
        w_inst_d    = r_inst;
        w_inst_pc_d = r_inst_pc;
        w_fault_d   = r_fault;
        unique case (r_state)
            StIdle: begin
                w_state_d = StReq;
                if (i_redirect_valid) w_pc_sel = PcRedirect;
            end
            StReq: begin
                if (i_redirect_valid) begin
                    w_pc_sel  = PcRedirect;
                    // An accepted request still owes a response that must be dropped.
                    w_state_d = w_req_fire ? StDrain : StReq;
                end else if (w_misaligned) begin
                    w_state_d   = StHold;
                    w_inst_d    = NOP;
                    w_inst_pc_d = w_pc;
                    w_fault_d   = 1'b1;
                end else if (w_req_fire) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_redirect_valid) begin
                    w_pc_sel  = PcRedirect;
                    w_state_d = i_imem_rsp_valid ? StReq : StDrain;
                end else if (i_imem_rsp_valid) begin
                    w_state_d   = StHold;
                    w_inst_d    = i_imem_rsp_data;
                    w_inst_pc_d = w_pc;
                    w_fault_d   = 1'b0;
                end
            end
            StHold: begin
                // Redirect wins over pc+4 even when decode takes the instruction.
                if (i_redirect_valid) begin
                    w_pc_sel  = PcRedirect;
                    w_state_d = StReq;
                    w_fault_d = 1'b0;
                end else if (i_inst_ready) begin
                    w_pc_sel  = PcInc;
                    w_state_d = StReq;
                    w_fault_d = 1'b0;
                end
            end
            StDrain: begin
                if (i_redirect_valid) w_pc_sel = PcRedirect;
                if (i_imem_rsp_valid) w_state_d = StReq;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_inst    <= w_inst_d;
            r_inst_pc <= w_inst_pc_d;
            r_fault   <= w_fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for ysyx_220053_ifu with a small instruction memory responder whose response
// latency is adjustable per scenario.
module tb_ysyx_220053_ifu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    // Memory responder: response arrives `lat` cycles after acceptance. Deliberately not reset,
    // so a response can land while the IFU is in reset or IDLE.
    int          lat = 1;
    int          cnt = 0;
    logic [63:0] paddr = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 32'h0010_0093;
        if (a == 64'h0000_0000_8000_0200) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (cnt != 0) cnt <= cnt - 1;
        if (req_valid && req_ready) begin
            cnt   <= lat;
            paddr <= req_addr;
        end
    end

    assign rsp_valid = (cnt == 1);
    assign rsp_data  = rsp_valid ? mem_word(paddr) : 32'h0;

    ysyx_220053_ifu dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_imem_req_valid(req_valid),
        .i_imem_req_ready(req_ready),
        .o_imem_req_addr (req_addr),
        .i_imem_rsp_valid(rsp_valid),
        .i_imem_rsp_data (rsp_data),
        .o_inst_valid    (inst_valid),
        .i_inst_ready    (inst_ready),
        .o_inst          (inst),
        .o_inst_pc       (inst_pc),
        .i_redirect_valid(redir_valid),
        .i_redirect_pc   (redir_pc),
        .o_fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst_valid(input string tag);
        int n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_valid: inst_valid=%b after %0d cycles, want 1", tag, inst_valid, n);
        end
    endtask

    task automatic handshake();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 64'h8000_0000 || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 64'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rv=%b addr=%h iv=%b inst=%h ipc=%h ff=%b, want 0 80000000 0 0 0 0",
                     req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault);
        end
        rst_n = 1'b1;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req_valid=%b want 0", req_valid);
        end
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL first_req: rv=%b addr=%h want 1 80000000", req_valid, req_addr);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: rv=%b iv=%b want 0 0", req_valid, inst_valid);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL first_inst: iv=%b inst=%h pc=%h want 1 00100093 80000000",
                     inst_valid, inst, inst_pc);
        end
        handshake();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0004 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL second_req: rv=%b addr=%h iv=%b want 1 80000004 0",
                     req_valid, req_addr, inst_valid);
        end
    endtask

    task automatic test_hold_stall();
        wait_inst_valid("stall");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst !== 32'hDA5A_0004 || inst_pc !== 64'h8000_0004 || req_valid !== 1'b0 ||
                inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: inst=%h pc=%h rv=%b iv=%b want DA5A0004 80000004 0 1",
                         i, inst, inst_pc, req_valid, inst_valid);
            end
            tick();
        end
        handshake();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0008) begin
            errors++;
            $display("FAIL stall_release: rv=%b addr=%h want 1 80000008", req_valid, req_addr);
        end
    endtask

    task automatic test_redirect_hold();
        wait_inst_valid("redir_hold");
        checks++;
        if (inst_pc !== 64'h8000_0008) begin
            errors++;
            $display("FAIL redir_hold_pc: inst_pc=%h want 80000008", inst_pc);
        end
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0200;
        tick();
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0200 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_hold_next: rv=%b addr=%h iv=%b want 1 80000200 0",
                     req_valid, req_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_wait();
        lat = 2;
        tick();
        checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_state: rv=%b iv=%b want 0 0", req_valid, inst_valid);
        end
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0100;
        tick();
        redir_valid = 1'b0;
        // Stale DEADBEEF response is on the bus during this cycle.
        checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drain: rv=%b iv=%b want 0 0", req_valid, inst_valid);
        end
        tick();
        lat = 1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_req: rv=%b addr=%h iv=%b want 1 80000100 0",
                     req_valid, req_addr, inst_valid);
        end
        wait_inst_valid("redir_wait");
        checks++;
        if (inst !== 32'hDA5A_0100 || inst_pc !== 64'h8000_0100) begin
            errors++;
            $display("FAIL redir_wait_inst: inst=%h pc=%h want DA5A0100 80000100", inst, inst_pc);
        end
        handshake();
    endtask

    task automatic test_wrap();
        req_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        req_ready   = 1'b1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: rv=%b addr=%h want 1 FFFFFFFFFFFFFFFC", req_valid, req_addr);
        end
        wait_inst_valid("wrap");
        checks++;
        if (inst !== 32'hA5A5_FFFC || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_inst: inst=%h pc=%h want A5A5FFFC FFFFFFFFFFFFFFFC", inst, inst_pc);
        end
        handshake();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap_next: rv=%b addr=%h want 1 0", req_valid, req_addr);
        end
    endtask

    task automatic test_align();
        req_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0002;
        tick();
        redir_valid = 1'b0;
        req_ready   = 1'b1;
`ifdef YSYX_220053_IFU_ALIGN_CHECK_EN
        checks++;
        if (req_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL align_noreq: rv=%b ff=%b want 0 0", req_valid, fetch_fault);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 64'h8000_0002 ||
            fetch_fault !== 1'b1 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_fault: iv=%b inst=%h pc=%h ff=%b rv=%b want 1 00000013 80000002 1 0",
                     inst_valid, inst, inst_pc, fetch_fault, req_valid);
        end
`else
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0002) begin
            errors++;
            $display("FAIL align_req: rv=%b addr=%h want 1 80000002", req_valid, req_addr);
        end
        wait_inst_valid("align");
        checks++;
        if (fetch_fault !== 1'b0 || inst !== 32'hDA5A_0002 || inst_pc !== 64'h8000_0002) begin
            errors++;
            $display("FAIL align_inst: ff=%b inst=%h pc=%h want 0 DA5A0002 80000002",
                     fetch_fault, inst, inst_pc);
        end
`endif
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0300;
        tick();
        redir_valid = 1'b0;
        checks++;
        if (fetch_fault !== 1'b0 || inst_valid !== 1'b0 || req_valid !== 1'b1 ||
            req_addr !== 64'h8000_0300) begin
            errors++;
            $display("FAIL align_leave: ff=%b iv=%b rv=%b addr=%h want 0 0 1 80000300",
                     fetch_fault, inst_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        lat = 3;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 64'h8000_0000 || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 64'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset: rv=%b addr=%h iv=%b inst=%h ipc=%h ff=%b, want 0 80000000 0 0 0 0",
                     req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault);
        end
        tick();
        tick();
        // Abandoned response is on the bus now; release reset so it lands in IDLE.
        rst_n = 1'b1;
        lat   = 1;
        checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL midwait_idle: rv=%b iv=%b want 0 0", req_valid, inst_valid);
        end
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL midwait_req: rv=%b addr=%h want 1 80000000", req_valid, req_addr);
        end
        wait_inst_valid("midwait");
        checks++;
        if (inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL midwait_inst: inst=%h pc=%h want 00100093 80000000", inst, inst_pc);
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        req_ready   = 1'b1;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        test_reset();
        test_hold_stall();
        test_redirect_hold();
        test_redirect_wait();
        test_wrap();
        test_align();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
